// File: rtl/mcpu_ext_io.sv
// External I/J/K register responder for the MCPU core: I is a byte stream
// (RX pop / TX push), J is status with sticky clears, K is control (loopback).
module mcpu_ext_io #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    inout  wire  [DATA_WIDTH-1:0] data_bus,
    input  logic [2:0]            regs_ext_re,
    input  logic [2:0]            regs_ext_we,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int RX = 0;
    localparam int TX = 1;

    logic [1:0]    push;
    logic [1:0]    pop;
    logic [7:0]    wdata [2];
    logic [7:0]    head  [2];
    logic [CW-1:0] cnt   [2];

    logic tx_over_q, tx_over_d;
    logic rx_under_q, rx_under_d;
    logic loopback_q, loopback_d;

    logic                  rx_empty, rx_full, tx_empty, tx_full;
    logic                  lb_move, ext_rx_push, ext_tx_pop;
    logic                  bus_drive;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [23:0]           status;
    logic [7:0]            tx_wdata;
    logic                  unused_bus;

    // Index 0 is the RX FIFO, index 1 the TX FIFO; head is read asynchronously.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [7:0]    mem [DEPTH];
            logic [AW-1:0] wr_ptr_q, rd_ptr_q;
            logic [CW-1:0] cnt_q, cnt_d;

            assign cnt_d   = cnt_q + CW'(push[gi]) - CW'(pop[gi]);
            assign cnt[gi] = cnt_q;
            assign head[gi] = mem[rd_ptr_q];

            always_ff @(posedge clk) begin
                if (push[gi]) mem[wr_ptr_q] <= wdata[gi];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                end else begin
                    if (push[gi]) wr_ptr_q <= wr_ptr_q + AW'(1);
                    if (pop[gi])  rd_ptr_q <= rd_ptr_q + AW'(1);
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign rx_empty = (cnt[RX] == '0);
    assign rx_full  = (cnt[RX] == CW'(DEPTH));
    assign tx_empty = (cnt[TX] == '0);
    assign tx_full  = (cnt[TX] == CW'(DEPTH));

    assign tx_valid = !tx_empty && !loopback_q && !reset;
    assign tx_data  = tx_valid ? head[TX] : 8'h00;
    assign rx_ready = !rx_full && !loopback_q && !reset;

    assign lb_move     = loopback_q && !tx_empty && !rx_full;
    assign ext_rx_push = rx_valid && rx_ready;
    assign ext_tx_pop  = tx_valid && tx_ready;

    assign status = {8'(cnt[TX]), 8'(cnt[RX]), 3'b000, rx_under_q, tx_over_q,
                     1'b0, !tx_full, !rx_empty};

    // Lowest asserted read strobe wins when several are (illegally) high.
    always_comb begin
        rd_data = '0;
        if (regs_ext_re[0])      rd_data = rx_empty ? '0 : DATA_WIDTH'(head[RX]);
        else if (regs_ext_re[1]) rd_data = DATA_WIDTH'(status);
        else if (regs_ext_re[2]) rd_data = DATA_WIDTH'(loopback_q);
    end

    assign bus_drive = (|regs_ext_re) && !reset;
    assign data_bus  = bus_drive ? rd_data : 'z;

    // MOV I,I echoes the byte the block itself is driving onto the bus.
    assign tx_wdata = regs_ext_re[0] ? rd_data[7:0] : data_bus[7:0];

    assign push[RX]  = ext_rx_push || lb_move;
    assign wdata[RX] = lb_move ? head[TX] : rx_data;
    assign pop[RX]   = regs_ext_re[0] && !rx_empty;
    assign push[TX]  = regs_ext_we[0] && !tx_full;
    assign wdata[TX] = tx_wdata;
    assign pop[TX]   = ext_tx_pop || lb_move;

    assign tx_over_d  = (tx_over_q  & ~(regs_ext_we[1] & data_bus[3])) | (regs_ext_we[0] & tx_full);
    assign rx_under_d = (rx_under_q & ~(regs_ext_we[1] & data_bus[4])) | (regs_ext_re[0] & rx_empty);
    assign loopback_d = regs_ext_we[2] ? data_bus[0] : loopback_q;

    assign unused_bus = ^data_bus[DATA_WIDTH-1:8];

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_over_q  <= 1'b0;
            rx_under_q <= 1'b0;
            loopback_q <= 1'b0;
        end else begin
            tx_over_q  <= tx_over_d;
            rx_under_q <= rx_under_d;
            loopback_q <= loopback_d;
        end
    end
endmodule

// File: tb/tb_mcpu_ext_io.sv
// Directed bench for mcpu_ext_io: status, RX/TX streaming, overflow,
// underflow, loopback, echo and mid-stream reset.
module tb_mcpu_ext_io;
    logic        clk = 1'b0;
    logic        reset;
    wire  [31:0] data_bus;
    logic [2:0]  regs_ext_re;
    logic [2:0]  regs_ext_we;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;

    logic        tb_bus_en;
    logic [31:0] tb_bus_val;
    logic [31:0] rv;
    int          n_cmp = 0;
    int          n_bad = 0;

    assign data_bus = tb_bus_en ? tb_bus_val : 'z;

    always #5 clk = ~clk;

    mcpu_ext_io #(.DATA_WIDTH(32), .DEPTH(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .data_bus    (data_bus),
        .regs_ext_re (regs_ext_re),
        .regs_ext_we (regs_ext_we),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int idx, output logic [31:0] v);
        regs_ext_re = 3'(1 << idx);
        #2;
        v = data_bus;
        next_cycle();
        regs_ext_re = 3'b000;
    endtask

    task automatic wr(input int idx, input logic [31:0] val);
        regs_ext_we = 3'(1 << idx);
        tb_bus_en   = 1'b1;
        tb_bus_val  = val;
        next_cycle();
        regs_ext_we = 3'b000;
        tb_bus_en   = 1'b0;
    endtask

    task automatic rx_push(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        next_cycle();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    initial begin
        reset = 1'b1; regs_ext_re = '0; regs_ext_we = '0;
        tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
        tb_bus_en = 1'b0; tb_bus_val = '0;
        next_cycle();
        next_cycle();
        #2;
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_tx_data",  32'(tx_data),  32'h0);
        check("rst_rx_ready", 32'(rx_ready), 32'h0);
        next_cycle();
        reset = 1'b0;
        #2;
        check("post_rst_rx_ready", 32'(rx_ready), 32'h1);
        next_cycle();
        rd(1, rv); check("reset_J", rv, 32'h0000_0002);

        // External RX then underflow
        rx_push(8'h41);
        rx_push(8'h42);
        rd(1, rv); check("rx2_J", rv, 32'h0000_0203);
        rd(0, rv); check("rx_I0", rv, 32'h41);
        rd(0, rv); check("rx_I1", rv, 32'h42);
        rd(0, rv); check("rx_I_empty", rv, 32'h0);
        rd(1, rv); check("underflow_J", rv, 32'h0000_0012);
        wr(1, 32'h10);
        rd(1, rv); check("clr_under_J", rv, 32'h0000_0002);

        // TX fill past full with the sink stalled
        for (int i = 0; i < 17; i++) wr(0, 32'h80 + i);
        rd(1, rv); check("tx_full_J", rv, 32'h0010_0008);
        #2;
        check("tx_valid_full", 32'(tx_valid), 32'h1);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #2;
            check($sformatf("tx_out%0d", i), 32'(tx_data), 32'h80 + i);
            next_cycle();
        end
        tx_ready = 1'b0;
        #2;
        check("tx_drained_valid", 32'(tx_valid), 32'h0);
        check("tx_drained_data",  32'(tx_data),  32'h0);
        next_cycle();
        wr(1, 32'h08);
        rd(1, rv); check("clr_over_J", rv, 32'h0000_0002);

        // Loopback: write at edge N, moved at N+1, readable in cycle N+2
        wr(2, 32'hFFFF_FFFF);
        rd(2, rv); check("K_set", rv, 32'h1);
        wr(0, 32'h0000_015A);
        #1;
        check("lb_tx_valid", 32'(tx_valid), 32'h0);
        check("lb_rx_ready", 32'(rx_ready), 32'h0);
        rd(1, rv); check("lb_mid_J", rv, 32'h0001_0002);
        rd(0, rv); check("lb_I", rv, 32'h5A);
        rd(1, rv); check("lb_after_J", rv, 32'h0000_0002);
        wr(2, 32'h0);
        rd(2, rv); check("K_clr", rv, 32'h0);
        #1;
        check("lb_off_rx_ready", 32'(rx_ready), 32'h1);

        // Echo: MOV I,I
        rx_push(8'h33);
        regs_ext_re = 3'b001;
        regs_ext_we = 3'b001;
        #2;
        check("echo_bus", data_bus, 32'h33);
        next_cycle();
        regs_ext_re = 3'b000;
        regs_ext_we = 3'b000;
        #1;
        check("echo_tx_valid", 32'(tx_valid), 32'h1);
        check("echo_tx_data",  32'(tx_data),  32'h33);
        rd(1, rv); check("echo_J", rv, 32'h0001_0002);

        // Reset with both FIFOs partly full and a sticky set
        rd(0, rv); check("pre_rst_I_empty", rv, 32'h0);
        wr(0, 32'h11);
        wr(0, 32'h22);
        rx_push(8'h77);
        rx_push(8'h78);
        rd(1, rv); check("pre_rst_J", rv, 32'h0003_0213);
        reset = 1'b1;
        #2;
        check("midrst_tx_valid", 32'(tx_valid), 32'h0);
        check("midrst_rx_ready", 32'(rx_ready), 32'h0);
        next_cycle();
        reset = 1'b0;
        #1;
        check("after_rst_tx_valid", 32'(tx_valid), 32'h0);
        rd(1, rv); check("after_rst_J", rv, 32'h0000_0002);
        rd(2, rv); check("after_rst_K", rv, 32'h0);
        rd(0, rv); check("after_rst_I", rv, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
